// File: rtl/spi_slave_tx_feeder_if.sv
// Bundles the system-side write bus and the transmitter byte handshake
// of the SPI-slave TX feeder. The feeder uses the slave modport; the
// system writer and the MISO transmitter together form the master side.
interface spi_slave_tx_feeder_if #(
   parameter int AW = 4
);
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          wr_overflow;
   logic          txd_en;
   logic [7:0]    txd_data;
   logic          txd_over;

   modport master (
      output wr_en, wr_data, txd_over,
      input  full, empty, level, wr_overflow, txd_en, txd_data
   );

   modport slave (
      input  wr_en, wr_data, txd_over,
      output full, empty, level, wr_overflow, txd_en, txd_data
   );
endinterface

// File: rtl/spi_slave_tx_feeder.sv
// Byte source for the SPI-slave MISO transmitter. Bytes written by the
// system are queued in a FIFO; one byte is kept staged on txd_data. The
// SPI bus is shadowed through the same 2-FF synchroniser depth as the
// transmitter, so the reload point seen here coincides with the
// transmitter's and the next byte is staged before it is needed.
module spi_slave_tx_feeder #(
   parameter int         DEPTH = 16,
   parameter int         AW    = 4,
   parameter logic [7:0] FILL  = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_slave_tx_feeder_if.slave bus,
   input  logic                 spi_cs,
   input  logic                 spi_sck,
   output logic                 underrun,
   output logic                 frame_abort,
   output logic [15:0]          bytes_sent
);

   // Staged register contents
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_REAL  = 2'd1;
   localparam logic [1:0] ST_FILL  = 2'd2;

   localparam logic [AW:0]   DEPTH_L   = DEPTH[AW:0];
   localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

   // Synchronisers: bit 0 is the first stage (s0), bit 1 the second (s1)
   logic [1:0]    cs_sync_r;
   logic [1:0]    sck_sync_r;
   logic          cs_act_s;
   logic          sck_neg_s;
   logic          cs_rise_s;
   logic          cs_fall_s;

   // FIFO
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic [AW:0]   level_nxt_s;
   logic          full_r;
   logic          empty_r;
   logic          wr_acc_s;
   logic          pop_s;
   logic          wr_overflow_r;

   // Staging
   logic [1:0]    stage_r;
   logic [1:0]    stage_nxt_s;
   logic [7:0]    txd_data_r;
   logic [7:0]    txd_data_nxt_s;
   logic          txd_en_r;
   logic          txd_en_nxt_s;
   logic          underrun_nxt_s;
   logic          underrun_r;
   logic          reload_s;
   logic          repl_win_s;

   // Frame tracking
   logic [2:0]    bcnt_r;
   logic          frame_abort_r;
   logic [15:0]   bytes_sent_r;

   assign cs_act_s  = ~cs_sync_r[1];
   assign sck_neg_s = sck_sync_r[1] & ~sck_sync_r[0];
   assign cs_rise_s = ~cs_sync_r[1] & cs_sync_r[0];
   assign cs_fall_s = cs_sync_r[1] & ~cs_sync_r[0];

   // The transmitter has shifted out bit 7; a CS release in the same cycle wins
   assign reload_s   = sck_neg_s & cs_act_s & (bcnt_r == 3'd0) & ~cs_rise_s;
   // A staged FILL may only be swapped away from the transmitter reload window
   assign repl_win_s = (bcnt_r != 3'd0) & (bcnt_r != 3'd7);

   assign wr_acc_s   = bus.wr_en & ~full_r;

   // Double-flop the raw SPI chip-select and clock into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_r  <= 2'b11;
         sck_sync_r <= 2'b00;
      end else begin
         cs_sync_r  <= {cs_sync_r[0], spi_cs};
         sck_sync_r <= {sck_sync_r[0], spi_sck};
      end
   end

   // Decide the next staged byte and whether the FIFO head is consumed
   always_comb begin
      pop_s          = 1'b0;
      stage_nxt_s    = stage_r;
      txd_data_nxt_s = txd_data_r;
      txd_en_nxt_s   = txd_en_r;
      underrun_nxt_s = 1'b0;
      if (cs_rise_s) begin
         if (stage_r == ST_FILL) begin
            stage_nxt_s  = ST_EMPTY;
            txd_en_nxt_s = 1'b0;
         end else if ((stage_r == ST_EMPTY) && !empty_r) begin
            pop_s          = 1'b1;
            stage_nxt_s    = ST_REAL;
            txd_data_nxt_s = mem_r[rd_ptr_r];
            txd_en_nxt_s   = 1'b1;
         end else begin
            stage_nxt_s = stage_r;
         end
      end else if (reload_s) begin
         txd_en_nxt_s = 1'b1;
         if (!empty_r) begin
            pop_s          = 1'b1;
            stage_nxt_s    = ST_REAL;
            txd_data_nxt_s = mem_r[rd_ptr_r];
         end else begin
            stage_nxt_s    = ST_FILL;
            txd_data_nxt_s = FILL;
            underrun_nxt_s = 1'b1;
         end
      end else begin
         case (stage_r)
            ST_EMPTY: begin
               if (!empty_r) begin
                  pop_s          = 1'b1;
                  stage_nxt_s    = ST_REAL;
                  txd_data_nxt_s = mem_r[rd_ptr_r];
                  txd_en_nxt_s   = 1'b1;
               end else begin
                  stage_nxt_s = ST_EMPTY;
               end
            end
            ST_FILL: begin
               if (!empty_r && repl_win_s) begin
                  pop_s          = 1'b1;
                  stage_nxt_s    = ST_REAL;
                  txd_data_nxt_s = mem_r[rd_ptr_r];
               end else begin
                  stage_nxt_s = ST_FILL;
               end
            end
            ST_REAL: begin
               stage_nxt_s = ST_REAL;
            end
            default: begin
               stage_nxt_s  = ST_EMPTY;
               txd_en_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // Next FIFO occupancy from the accepted write and the pop
   always_comb begin
      level_nxt_s = level_r;
      case ({wr_acc_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // FIFO storage; contents need no reset because occupancy guards reads
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= bus.wr_data;
      end
   end

   // FIFO pointers, registered flags and the overflow pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r      <= {AW{1'b0}};
         rd_ptr_r      <= {AW{1'b0}};
         level_r       <= {(AW+1){1'b0}};
         full_r        <= 1'b0;
         empty_r       <= 1'b1;
         wr_overflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r       <= level_nxt_s;
         full_r        <= (level_nxt_s == DEPTH_L);
         empty_r       <= (level_nxt_s == {(AW+1){1'b0}});
         wr_overflow_r <= bus.wr_en & full_r;
      end
   end

   // Staged byte register and underrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_r    <= ST_EMPTY;
         txd_data_r <= 8'h00;
         txd_en_r   <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         stage_r    <= stage_nxt_s;
         txd_data_r <= txd_data_nxt_s;
         txd_en_r   <= txd_en_nxt_s;
         underrun_r <= underrun_nxt_s;
      end
   end

   // Bit position within the current byte and aborted-frame detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_r        <= 3'd0;
         frame_abort_r <= 1'b0;
      end else begin
         frame_abort_r <= cs_rise_s & (bcnt_r != 3'd0);
         if (cs_rise_s) begin
            bcnt_r <= 3'd0;
         end else if (sck_neg_s && cs_act_s) begin
            bcnt_r <= bcnt_r + 3'd1;
         end
      end
   end

   // Bytes completed by the transmitter since the frame started
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bytes_sent_r <= 16'd0;
      end else if (cs_fall_s) begin
         bytes_sent_r <= 16'd0;
      end else if (bus.txd_over) begin
         bytes_sent_r <= bytes_sent_r + 16'd1;
      end
   end

   assign bus.full        = full_r;
   assign bus.empty       = empty_r;
   assign bus.level       = level_r;
   assign bus.wr_overflow = wr_overflow_r;
   assign bus.txd_en      = txd_en_r;
   assign bus.txd_data    = txd_data_r;
   assign underrun        = underrun_r;
   assign frame_abort     = frame_abort_r;
   assign bytes_sent      = bytes_sent_r;

endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// Directed bench for spi_slave_tx_feeder: drives system writes, a mode-0
// SPI clock/chip-select and transmitter byte-done pulses, and compares
// outputs against hand-derived values on the falling clock edge.
module tb_spi_slave_tx_feeder;

   logic        clk;
   logic        rst_n;
   logic        spi_cs;
   logic        spi_sck;
   logic        underrun;
   logic        frame_abort;
   logic [15:0] bytes_sent;

   int n_checks;
   int n_fail;
   int urun_cnt;
   int abort_cnt;
   int ovf_cnt;
   int u0;
   int a0;
   int o0;

   spi_slave_tx_feeder_if #(.AW(4)) bus ();

   spi_slave_tx_feeder #(
      .DEPTH (16),
      .AW    (4),
      .FILL  (8'hFF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .spi_cs      (spi_cs),
      .spi_sck     (spi_sck),
      .underrun    (underrun),
      .frame_abort (frame_abort),
      .bytes_sent  (bytes_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one-cycle pulses; a pulse from edge k is seen at edge k+1
   always @(posedge clk) begin
      urun_cnt  <= urun_cnt  + ((underrun        === 1'b1) ? 1 : 0);
      abort_cnt <= abort_cnt + ((frame_abort     === 1'b1) ? 1 : 0);
      ovf_cnt   <= ovf_cnt   + ((bus.wr_overflow === 1'b1) ? 1 : 0);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick(1);
      bus.wr_en   = 1'b0;
   endtask

   // One full SCK period of 8 clk: rise, then fall, then low time
   task automatic sck_pulse();
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
      tick(4);
   endtask

   task automatic over_pulse();
      bus.txd_over = 1'b1;
      tick(1);
      bus.txd_over = 1'b0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      spi_cs       = 1'b1;
      spi_sck      = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_data  = 8'h00;
      bus.txd_over = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   // Safety net in case the sequence ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      urun_cnt  = 0;
      abort_cnt = 0;
      ovf_cnt   = 0;

      // Reset state, sampled while rst_n is held low
      rst_n        = 1'b0;
      spi_cs       = 1'b1;
      spi_sck      = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_data  = 8'h00;
      bus.txd_over = 1'b0;
      tick(2);
      check_val("rst_level",    32'(bus.level), 32'd0);
      check_val("rst_full",     32'(bus.full), 32'd0);
      check_val("rst_empty",    32'(bus.empty), 32'd1);
      check_val("rst_txd_en",   32'(bus.txd_en), 32'd0);
      check_val("rst_txd_data", 32'(bus.txd_data), 32'd0);
      check_val("rst_bytes",    32'(bytes_sent), 32'd0);
      check_val("rst_pulses",   32'({underrun, frame_abort, bus.wr_overflow}), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // 1: two bytes through a 16-SCK frame
      push(8'hA5);
      tick(1);
      check_val("t1_stage_a5", 32'(bus.txd_data), 32'hA5);
      check_val("t1_txd_en",   32'(bus.txd_en), 32'd1);
      push(8'h3C);
      tick(1);
      check_val("t1_level1", 32'(bus.level), 32'd1);
      spi_cs = 1'b0;
      tick(4);
      u0 = urun_cnt;
      a0 = abort_cnt;
      for (int i = 1; i <= 16; i++) begin
         sck_pulse();
         if (i == 1) check_val("t1_stage_3c", 32'(bus.txd_data), 32'h3C);
         if (i == 8 || i == 16) over_pulse();
      end
      check_val("t1_bytes_sent", 32'(bytes_sent), 32'd2);
      check_val("t1_empty",      32'(bus.empty), 32'd1);
      check_val("t1_underruns",  32'(urun_cnt - u0), 32'd1);
      spi_cs = 1'b1;
      tick(4);
      check_val("t1_fill_dropped", 32'(bus.txd_en), 32'd0);
      check_val("t1_no_abort",     32'(abort_cnt - a0), 32'd0);

      // 2: CS fall together with txd_over gives 0, then underrun at first reload
      push(8'h81);
      tick(1);
      check_val("t2_stage_81", 32'(bus.txd_data), 32'h81);
      spi_cs = 1'b0;
      tick(1);
      bus.txd_over = 1'b1;
      tick(1);
      bus.txd_over = 1'b0;
      check_val("t2_fall_over_clear", 32'(bytes_sent), 32'd0);
      tick(2);
      u0 = urun_cnt;
      sck_pulse();
      check_val("t2_fill_data",  32'(bus.txd_data), 32'hFF);
      check_val("t2_fill_en",    32'(bus.txd_en), 32'd1);
      check_val("t2_underrun_1", 32'(urun_cnt - u0), 32'd1);
      for (int i = 2; i <= 16; i++) sck_pulse();
      check_val("t2_underrun_2", 32'(urun_cnt - u0), 32'd2);
      spi_cs = 1'b1;
      tick(4);
      check_val("t2_txd_en_off", 32'(bus.txd_en), 32'd0);

      // 3: 18 back-to-back writes, no SPI activity
      do_reset();
      o0 = ovf_cnt;
      bus.wr_en = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         bus.wr_data = 8'(i);
         tick(1);
      end
      bus.wr_en = 1'b0;
      tick(2);
      check_val("t3_staged", 32'(bus.txd_data), 32'h01);
      check_val("t3_level",  32'(bus.level), 32'd16);
      check_val("t3_full",   32'(bus.full), 32'd1);
      check_val("t3_ovf",    32'(ovf_cnt - o0), 32'd1);

      // 4: 5-SCK frame then CS high aborts; staged byte survives
      spi_cs = 1'b0;
      tick(4);
      a0 = abort_cnt;
      for (int i = 1; i <= 5; i++) sck_pulse();
      spi_cs = 1'b1;
      tick(4);
      check_val("t4_abort",    32'(abort_cnt - a0), 32'd1);
      check_val("t4_kept",     32'(bus.txd_data), 32'h02);
      check_val("t4_kept_en",  32'(bus.txd_en), 32'd1);
      spi_cs = 1'b0;
      tick(4);
      sck_pulse();
      check_val("t4_bcnt_zero", 32'(bus.txd_data), 32'h03);
      check_val("t4_level",     32'(bus.level), 32'd14);
      spi_cs = 1'b1;
      tick(4);

      // 5: FILL replaced at bcnt 3, kept at bcnt 7 and 0
      do_reset();
      spi_cs = 1'b0;
      tick(4);
      u0 = urun_cnt;
      for (int i = 1; i <= 3; i++) sck_pulse();
      check_val("t5_fill",    32'(bus.txd_data), 32'hFF);
      check_val("t5_urun",    32'(urun_cnt - u0), 32'd1);
      u0 = urun_cnt;
      push(8'h42);
      tick(1);
      check_val("t5_replace", 32'(bus.txd_data), 32'h42);
      check_val("t5_level0",  32'(bus.level), 32'd0);
      tick(2);
      check_val("t5_no_urun", 32'(urun_cnt - u0), 32'd0);
      for (int i = 4; i <= 9; i++) sck_pulse();
      check_val("t5_fill2",   32'(bus.txd_data), 32'hFF);
      for (int i = 10; i <= 15; i++) sck_pulse();
      push(8'h43);
      tick(2);
      check_val("t5_bcnt7_kept",  32'(bus.txd_data), 32'hFF);
      check_val("t5_bcnt7_level", 32'(bus.level), 32'd1);
      sck_pulse();
      check_val("t5_bcnt0_kept",  32'(bus.txd_data), 32'hFF);
      sck_pulse();
      check_val("t5_reload_43",   32'(bus.txd_data), 32'h43);
      check_val("t5_level_end",   32'(bus.level), 32'd0);
      spi_cs = 1'b1;
      tick(4);

      // 6: asynchronous reset mid-frame with 4 bytes queued
      do_reset();
      for (int i = 1; i <= 6; i++) push(8'(8'h10 * i + i));
      tick(1);
      spi_cs = 1'b0;
      tick(4);
      for (int i = 1; i <= 3; i++) sck_pulse();
      check_val("t6_pre_level", 32'(bus.level), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_level",    32'(bus.level), 32'd0);
      check_val("t6_txd_en",   32'(bus.txd_en), 32'd0);
      check_val("t6_txd_data", 32'(bus.txd_data), 32'd0);
      check_val("t6_flags",    32'({bus.full, bus.empty}), 32'd1);
      check_val("t6_pulses",   32'({underrun, frame_abort, bus.wr_overflow}), 32'd0);
      check_val("t6_bytes",    32'(bytes_sent), 32'd0);
      spi_cs = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      push(8'h66);
      tick(1);
      check_val("t6_after_data", 32'(bus.txd_data), 32'h66);
      check_val("t6_after_en",   32'(bus.txd_en), 32'd1);
      check_val("t6_after_lvl",  32'(bus.level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
